// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART receiver slice:
//     - uart_state_e  : encoding of the receive frame FSM
//     - PARITY_*      : parity mode constants used by the PARITY parameter
//     - parity_error(): parity check for one received frame
//   No ports; imported by uart_rx_fifo.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // data_xor is the XOR of all received data bits, sample is the received
    // parity bit. With even parity the XOR of data and parity must be 0,
    // with odd parity it must be 1; anything else is an error.
    function automatic logic parity_error(input logic data_xor,
                                          input logic sample,
                                          input logic odd_mode);
        return ((data_xor ^ sample) != odd_mode);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with show-ahead head data.
//   Ports:
//     clk, rst_n        : clock, asynchronous active-low reset
//     wr_en, wr_data    : push request and data
//     rd_en             : pop request (ignored while empty)
//     rd_data           : head entry, forced to 0 while empty
//     valid             : FIFO not empty
//     full              : FIFO full
//   A push while full is accepted only if a pop happens in the same cycle;
//   otherwise the write is dropped and the FIFO is left unchanged.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the
    // address bits match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic empty;
    logic do_push;
    logic do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = rd_en & ~empty;
    // When full, the slot being freed by a same-cycle pop is the one written.
    assign do_push = wr_en & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign valid   = ~empty;
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   UART receiver with a frame FIFO on the output side.
//   Parameters:
//     WAIT_DIV   : clock cycles per UART bit (4..65535)
//     DATA_BITS  : data bits per frame (5..9)
//     PARITY     : PARITY_NONE / PARITY_EVEN / PARITY_ODD
//     STOP_BITS  : stop bits checked per frame (1 or 2)
//     FIFO_DEPTH : received-frame entries (power of two, 2..64)
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     uart_in    : asynchronous serial input, idle high
//     rdata      : data of the FIFO head entry
//     rerr       : head entry flags {parity_err, frame_err}
//     rvalid     : FIFO not empty
//     rready     : consumer pop request
//     overflow   : sticky flag, a frame was lost because the FIFO was full
//     clr_ovf    : synchronous clear of overflow
//     busy       : receiver not in IDLE
//     dbg_state  : current frame FSM state
//
//   Read handshake: the head entry (rdata/rerr) is presented while
//   rvalid=1 and held stable until it is popped; a pop happens on a clock
//   edge where rvalid=1 and rready=1. rready while rvalid=0 has no effect.
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WAIT_DIV   = 8,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_in,
    output logic [DATA_BITS-1:0] rdata,
    output logic [1:0]           rerr,
    output logic                 rvalid,
    input  logic                 rready,
    output logic                 overflow,
    input  logic                 clr_ovf,
    output logic                 busy,
    output uart_state_e          dbg_state
);

    localparam int          ENTRY_W    = DATA_BITS + 2;
    localparam logic [15:0] HALF_LAST  = 16'(WAIT_DIV / 2 - 1);
    localparam logic [15:0] BIT_LAST   = 16'(WAIT_DIV - 1);
    localparam logic [3:0]  DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]  STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic        HAS_PARITY = (PARITY != PARITY_NONE);
    localparam logic        ODD_MODE   = (PARITY == PARITY_ODD);

    // ------------------------------------------------------------------
    // Input synchroniser; reset to the idle line level so that a reset
    // never looks like a start bit.
    // ------------------------------------------------------------------
    logic sync1;
    logic sync2;
    logic rx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= uart_in;
            sync2 <= sync1;
        end
    end

    assign rx = sync2;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    uart_state_e          state;
    logic [15:0]          baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_err;
    logic                 frame_err;
    logic                 push_valid;
    logic [ENTRY_W-1:0]   push_word;
    logic                 busy_q;
    logic                 baud_tick;

    // In START the counter only runs to the half-bit point; after that every
    // sample is one full bit period later, so samples land mid-bit.
    assign baud_tick = (baud_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_err    <= 1'b0;
            frame_err  <= 1'b0;
            push_valid <= 1'b0;
            push_word  <= '0;
            busy_q     <= 1'b0;
        end else begin
            push_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx) begin
                        state     <= ST_START;
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                        par_err   <= 1'b0;
                        frame_err <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end

                ST_START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        if (!rx) begin
                            state <= ST_DATA;
                        end else begin
                            // Line went back high: a glitch, not a start bit.
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                ST_DATA: begin
                    if (baud_tick) begin
                        baud_cnt  <= '0;
                        // LSB arrives first, so shift in from the top.
                        shift_reg <= {rx, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= HAS_PARITY ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                ST_PARITY: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        par_err  <= parity_error(^shift_reg, rx, ODD_MODE);
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                ST_STOP: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        if (!rx) begin
                            frame_err <= 1'b1;
                        end
                        if (bit_cnt == STOP_LAST) begin
                            // The last stop sample is folded in directly so
                            // the entry is complete on the push cycle.
                            bit_cnt    <= '0;
                            state      <= ST_IDLE;
                            busy_q     <= 1'b0;
                            push_valid <= 1'b1;
                            push_word  <= {par_err, frame_err | ~rx, shift_reg};
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign dbg_state = state;

    // ------------------------------------------------------------------
    // Frame FIFO and overflow tracking
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] head;
    logic               fifo_full;
    logic               pop;
    logic               ovf_event;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push_valid),
        .wr_data (push_word),
        .rd_en   (rready),
        .rd_data (head),
        .valid   (rvalid),
        .full    (fifo_full)
    );

    assign pop       = rvalid & rready;
    // A same-cycle pop makes room, so only an unmatched push into a full
    // FIFO loses a frame.
    assign ovf_event = push_valid & fifo_full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (ovf_event) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign rdata = head[DATA_BITS-1:0];
    assign rerr  = head[ENTRY_W-1:DATA_BITS];

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int WAIT_DIV = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT A: defaults (8N1) ----------------
    logic        line_a, rready_a, clr_a;
    logic [7:0]  rdata_a;
    logic [1:0]  rerr_a;
    logic        rvalid_a, ovf_a, busy_a;
    uart_state_e st_a;

    uart_rx_fifo dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_in   (line_a),
        .rdata     (rdata_a),
        .rerr      (rerr_a),
        .rvalid    (rvalid_a),
        .rready    (rready_a),
        .overflow  (ovf_a),
        .clr_ovf   (clr_a),
        .busy      (busy_a),
        .dbg_state (st_a)
    );

    // ---------------- DUT B: even parity ----------------
    logic        line_b, rready_b, clr_b;
    logic [7:0]  rdata_b;
    logic [1:0]  rerr_b;
    logic        rvalid_b, ovf_b, busy_b;
    uart_state_e st_b;

    uart_rx_fifo #(.PARITY(PARITY_EVEN)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_in   (line_b),
        .rdata     (rdata_b),
        .rerr      (rerr_b),
        .rvalid    (rvalid_b),
        .rready    (rready_b),
        .overflow  (ovf_b),
        .clr_ovf   (clr_b),
        .busy      (busy_b),
        .dbg_state (st_b)
    );

    // ---------------- scoreboard ----------------
    int         checks   = 0;
    int         failures = 0;
    logic [9:0] exp_q[$];   // {rerr, rdata} expected from DUT A, in order

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input bit sel, input logic v);
        if (sel) line_b = v;
        else     line_a = v;
        repeat (WAIT_DIV) @(negedge clk);
    endtask

    // Returns at the end of the stop bit with the line back at idle.
    task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                              input logic par_bit, input logic stop_bit);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (has_par) drive_bit(sel, par_bit);
        drive_bit(sel, stop_bit);
        if (sel) line_b = 1'b1;
        else     line_a = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        repeat (n * WAIT_DIV) @(negedge clk);
    endtask

    task automatic wait_valid(input bit sel, input string tag, input int budget);
        int n = 0;
        while (!(sel ? rvalid_b : rvalid_a) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rvalid"}, 32'(sel ? rvalid_b : rvalid_a), 32'd1);
    endtask

    task automatic pop_a(input string tag);
        logic [9:0] e;
        wait_valid(1'b0, tag, 2 * WAIT_DIV);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
        chk({tag, "_rdata"}, 32'(rdata_a), 32'(e[7:0]));
        chk({tag, "_rerr"},  32'(rerr_a),  32'(e[9:8]));
        rready_a = 1'b1;
        @(negedge clk);
        rready_a = 1'b0;
    endtask

    task automatic pop_b(input string tag, input logic [7:0] ed, input logic [1:0] ee);
        wait_valid(1'b1, tag, 2 * WAIT_DIV);
        chk({tag, "_rdata"}, 32'(rdata_b), 32'(ed));
        chk({tag, "_rerr"},  32'(rerr_b),  32'(ee));
        rready_b = 1'b1;
        @(negedge clk);
        rready_b = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] ovf_data [5];
        logic [7:0] partial;
        logic       seen;
        int         n;

        line_a = 1'b1; line_b = 1'b1;
        rready_a = 1'b0; rready_b = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_rvalid",   32'(rvalid_a), 32'd0);
        chk("rst_busy",     32'(busy_a),   32'd0);
        chk("rst_overflow", 32'(ovf_a),    32'd0);
        chk("rst_rdata",    32'(rdata_a),  32'd0);
        chk("rst_rerr",     32'(rerr_a),   32'd0);
        chk("rst_state",    32'(st_a),     32'(ST_IDLE));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // rready on an empty FIFO is ignored
        rready_a = 1'b1;
        @(negedge clk);
        rready_a = 1'b0;
        chk("empty_pop_rvalid", 32'(rvalid_a), 32'd0);

        // 0x41 8N1; rvalid due within WAIT_DIV+4 of the stop midpoint,
        // i.e. WAIT_DIV/2+4 cycles after the stop bit ends.
        send_frame(1'b0, 8'h41, 1'b0, 1'b0, 1'b1);
        exp_q.push_back({2'b00, 8'h41});
        wait_valid(1'b0, "t41_latency", WAIT_DIV / 2 + 4);
        repeat (3) @(negedge clk);
        chk("t41_hold_rdata", 32'(rdata_a), 32'h41);
        pop_a("t41");
        chk("t41_empty", 32'(rvalid_a), 32'd0);
        idle_bits(1);

        // Even parity on DUT B: 0x0D has three ones, parity bit 0 is wrong
        send_frame(1'b1, 8'h0D, 1'b1, 1'b0, 1'b1);
        idle_bits(1);
        pop_b("par0d", 8'h0D, 2'b10);
        // 0x41 has two ones, parity bit 0 is right
        send_frame(1'b1, 8'h41, 1'b1, 1'b0, 1'b1);
        idle_bits(1);
        pop_b("par41", 8'h41, 2'b00);
        chk("par_empty", 32'(rvalid_b), 32'd0);

        // Stop bit driven low, then a clean frame
        send_frame(1'b0, 8'h68, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({2'b01, 8'h68});
        idle_bits(2);
        send_frame(1'b0, 8'h65, 1'b0, 1'b0, 1'b1);
        exp_q.push_back({2'b00, 8'h65});
        idle_bits(1);
        pop_a("ferr68");
        pop_a("clean65");
        chk("ferr_empty", 32'(rvalid_a), 32'd0);

        // Two-clock low glitch on an idle line
        line_a = 1'b0;
        repeat (2) @(negedge clk);
        line_a = 1'b1;
        @(negedge clk);
        chk("glitch_busy_seen", 32'(busy_a), 32'd1);
        n = 0;
        while (busy_a && n < WAIT_DIV) begin
            @(negedge clk);
            n++;
        end
        chk("glitch_busy_clear", 32'(busy_a), 32'd0);
        idle_bits(2);
        chk("glitch_no_push", 32'(rvalid_a), 32'd0);

        // Overflow: five frames into a four-entry FIFO with no pops
        ovf_data[0] = 8'h65; ovf_data[1] = 8'h78; ovf_data[2] = 8'h69;
        ovf_data[3] = 8'h74; ovf_data[4] = 8'h0D;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk("ovf_before", 32'(ovf_a), 32'd0);
            send_frame(1'b0, ovf_data[i], 1'b0, 1'b0, 1'b1);
            if (i < 4) exp_q.push_back({2'b00, ovf_data[i]});
            idle_bits(1);
        end
        chk("ovf_set", 32'(ovf_a), 32'd1);
        for (int i = 0; i < 4; i++) pop_a($sformatf("ovf_pop%0d", i));
        chk("ovf_drained", 32'(rvalid_a), 32'd0);
        chk("ovf_sticky", 32'(ovf_a), 32'd1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        chk("ovf_cleared", 32'(ovf_a), 32'd0);

        // Reset during bit 3 of 0x41, then 0x6C
        partial = 8'h41;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0, partial[i]);
        line_a = partial[3];
        repeat (WAIT_DIV / 2) @(negedge clk);
        chk("rst_mid_busy_before", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy_a), 32'd0);
        chk("rst_mid_state", 32'(st_a), 32'(ST_IDLE));
        line_a = 1'b1;
        repeat (WAIT_DIV) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(2);
        chk("rst_mid_no_push", 32'(rvalid_a), 32'd0);
        send_frame(1'b0, 8'h6C, 1'b0, 1'b0, 1'b1);
        exp_q.push_back({2'b00, 8'h6C});
        idle_bits(1);
        pop_a("after_rst6c");
        chk("after_rst_empty", 32'(rvalid_a), 32'd0);
        seen = (exp_q.size() == 0);
        chk("exp_q_drained", 32'(seen), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
